mux_reg_arbiter: RTL and testbench

Two-requester arbiter that shares one registered WIDTH-bit mux datapath between two sources. Each source raises a request; the block grants one at a time, drives the mux select and the capture enable, and registers the selected data into d_out1. It sits directly in front of consumers of the shared mux-register path and replaces free-running sel/en control with round-robin, optionally time-sliced, ownership.

---
 rtl/mux_reg_arbiter_if.sv | 25 ++
 rtl/mux_reg_arbiter.sv | 119 +++++++++++
 tb/tb_mux_reg_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mux_reg_arbiter_if.sv
// Request/grant and data bundle between two sources and the shared mux-register arbiter.
interface mux_reg_arbiter_if #(
    parameter int WIDTH = 3
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d_in1;
    logic [WIDTH-1:0] d_in2;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             en;
    logic [WIDTH-1:0] d_out1;
    logic             d_valid;

    modport master (
        output req0, req1, d_in1, d_in2,
        input  gnt0, gnt1, sel, en, d_out1, d_valid
    );

    modport slave (
        input  req0, req1, d_in1, d_in2,
        output gnt0, gnt1, sel, en, d_out1, d_valid
    );
endinterface

// File: rtl/mux_reg_arbiter.sv
// Round-robin two-source arbiter owning one registered WIDTH-bit mux datapath.
// Define MUX_ARB_HOLD_LIMIT_EN to preempt an owner after MAX_HOLD consecutive captures.
module mux_reg_arbiter #(
    parameter int WIDTH    = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    mux_reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
        $error("mux_reg_arbiter: MAX_HOLD must be in 1..15");
    end

    state_t           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             d_valid_q, d_valid_d;
    logic             en_w;
    logic             hold_hit_w;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    localparam logic [3:0] HOLD_M1  = 4'(MAX_HOLD - 1);

    logic [3:0] cnt_q, cnt_d;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= HOLD_MAX) ? HOLD_MAX : c + 4'd1;
    endfunction

    // The capture happening at this edge is the MAX_HOLD-th of the run.
    assign hold_hit_w = (cnt_q >= HOLD_M1);
`else
    assign hold_hit_w = 1'b0;
`endif

    assign en_w = ((state_q == OWN0) && bus.req0) || ((state_q == OWN1) && bus.req1);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        d_out_d      = d_out_q;
        d_valid_d    = 1'b0;

        if (en_w) begin
            d_out_d   = (state_q == OWN1) ? bus.d_in2 : bus.d_in1;
            d_valid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1)
                    state_d = last_owner_q ? OWN0 : OWN1;
                else if (bus.req0)
                    state_d = OWN0;
                else if (bus.req1)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!bus.req0)
                    state_d = bus.req1 ? OWN1 : IDLE;
                else if (hold_hit_w && bus.req1)
                    state_d = OWN1;
            end
            OWN1: begin
                if (!bus.req1)
                    state_d = bus.req0 ? OWN0 : IDLE;
                else if (hold_hit_w && bus.req0)
                    state_d = OWN0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == OWN0 && state_q != OWN0) last_owner_d = 1'b0;
        if (state_d == OWN1 && state_q != OWN1) last_owner_d = 1'b1;
    end

`ifdef MUX_ARB_HOLD_LIMIT_EN
    // Counter runs only while the same owner keeps capturing; any handover or drop restarts it.
    always_comb begin
        cnt_d = 4'd0;
        if (en_w && state_d == state_q)
            cnt_d = sat_inc(cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            d_out_q      <= '0;
            d_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            d_out_q      <= d_out_d;
            d_valid_q    <= d_valid_d;
        end
    end

    assign bus.gnt0    = (state_q == OWN0);
    assign bus.gnt1    = (state_q == OWN1);
    assign bus.sel     = (state_q == OWN1);
    assign bus.en      = en_w;
    assign bus.d_out1  = d_out_q;
    assign bus.d_valid = d_valid_q;
endmodule

// File: tb/tb_mux_reg_arbiter.sv
// Directed bench for mux_reg_arbiter with expectations worked out by hand.
module tb_mux_reg_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mux_reg_arbiter_if #(.WIDTH(3)) bus ();

    mux_reg_arbiter #(.WIDTH(3), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.d_in1 = 3'd0;
        bus.d_in2 = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_en", bus.en, 0);
        chk("rst_dout", bus.d_out1, 0);
        chk("rst_dvalid", bus.d_valid, 0);

        // Single source 0
        bus.req0 = 1'b1;
        bus.d_in1 = 3'd6;
        tick();
        chk("single_gnt0", bus.gnt0, 1);
        chk("single_sel", bus.sel, 0);
        chk("single_en", bus.en, 1);
        chk("single_dvalid_e1", bus.d_valid, 0);
        tick();
        chk("single_dout", bus.d_out1, 6);
        chk("single_dvalid", bus.d_valid, 1);

        // Source 0 drops while source 1 waits: bubble then capture of d_in2
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.d_in2 = 3'd2;
        tick();
        chk("mv1_gnt1", bus.gnt1, 1);
        chk("mv1_sel", bus.sel, 1);
        chk("mv1_bubble", bus.d_valid, 0);
        chk("mv1_hold", bus.d_out1, 6);
        tick();
        chk("mv1_dout", bus.d_out1, 2);
        chk("mv1_dvalid", bus.d_valid, 1);

        // Owner 1 drops while source 0 waits
        bus.req1 = 1'b0;
        bus.req0 = 1'b1;
        bus.d_in1 = 3'b101;
        tick();
        chk("mv0_gnt0", bus.gnt0, 1);
        chk("mv0_gnt1", bus.gnt1, 0);
        chk("mv0_bubble", bus.d_valid, 0);
        chk("mv0_hold", bus.d_out1, 2);
        tick();
        chk("mv0_dout", bus.d_out1, 5);
        chk("mv0_dvalid", bus.d_valid, 1);

        // Asynchronous reset in mid-cycle
        #3;
        reset = 1'b1;
        #1;
        chk("arst_dout", bus.d_out1, 0);
        chk("arst_gnt0", bus.gnt0, 0);
        chk("arst_dvalid", bus.d_valid, 0);
        chk("arst_en", bus.en, 0);
        chk("arst_sel", bus.sel, 0);
        tick();
        reset = 1'b0;

        // First tie after reset goes to source 0, then both keep requesting
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d_in1 = 3'd4;
        bus.d_in2 = 3'd7;
        tick();
        chk("tie_gnt0", bus.gnt0, 1);
        chk("tie_gnt1", bus.gnt1, 0);
        tick();
        chk("hold_c1_dout", bus.d_out1, 4);
        chk("hold_c1_dvalid", bus.d_valid, 1);
        tick();
        chk("hold_c2_gnt0", bus.gnt0, 1);
        tick();
        chk("hold_c3_gnt0", bus.gnt0, 1);
        tick();
        chk("hold_c4_dout", bus.d_out1, 4);
        chk("hold_c4_dvalid", bus.d_valid, 1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
        chk("hold_c4_gnt1", bus.gnt1, 1);
        tick();
        chk("hold_nobubble_dout", bus.d_out1, 7);
        chk("hold_nobubble_dvalid", bus.d_valid, 1);
        bus.req0 = 1'b0;
        tick();
        chk("hold_tail_gnt1", bus.gnt1, 1);
        chk("hold_tail_dvalid", bus.d_valid, 1);
        tick();
        chk("hold_tail_dout", bus.d_out1, 7);
`else
        chk("hold_c4_gnt0", bus.gnt0, 1);
        tick();
        chk("nohold_c5_gnt0", bus.gnt0, 1);
        chk("nohold_c5_dout", bus.d_out1, 4);
        bus.req0 = 1'b0;
        tick();
        chk("nohold_mv_gnt1", bus.gnt1, 1);
        chk("nohold_bubble", bus.d_valid, 0);
        tick();
        chk("nohold_dout", bus.d_out1, 7);
        chk("nohold_dvalid", bus.d_valid, 1);
`endif

        // Reset, give source 0 one grant, return to idle, then tie goes to source 1
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        reset = 1'b0;
        bus.req0 = 1'b1;
        bus.d_in1 = 3'd1;
        tick();
        chk("rr_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        tick();
        chk("rr_idle_gnt0", bus.gnt0, 0);
        chk("rr_idle_gnt1", bus.gnt1, 0);
        chk("rr_idle_dvalid", bus.d_valid, 0);
        chk("rr_idle_dout", bus.d_out1, 0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d_in2 = 3'd3;
        tick();
        chk("rr_tie_gnt1", bus.gnt1, 1);
        chk("rr_tie_sel", bus.sel, 1);
        tick();
        chk("rr_tie_dout", bus.d_out1, 3);
        chk("rr_tie_dvalid", bus.d_valid, 1);
        bus.req1 = 1'b0;
        #1;
        chk("en_comb_low", bus.en, 0);
        chk("en_comb_gnt1", bus.gnt1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
